coin_acceptor: RTL and testbench

Upstream front end of the vending machine. It conditions two raw coin-sensor lines (5-unit and 10-unit slots) and emits one coin code per accepted coin on the 2-bit coin bus. Coding: 0 = none, 1 = 5-unit coin, 2 = 10-unit coin. It synchronises and debounces the sensor lines, detects jams, and buffers coins in a small FIFO. Output is paced so the vending machine sees each coin as exactly one clock cycle of a non-zero code.

---
 rtl/coin_acceptor.sv | 95 +++++++++
 tb/tb_coin_acceptor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// coin_acceptor: sensor conditioning, jam detection, coin FIFO and paced coin-code output
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coin5_raw,
  input  logic                          coin10_raw,
  input  logic                          enable,
  output logic [1:0]                    coin_code,
  output logic                          reject,
  output logic                          jam,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    accepted_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;
  state_t state, state_n;
  logic [1:0] raw, s0, s1, lvl, lvl_q, ev;
  logic [CW-1:0] cnt [2];
  logic [1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [GW-1:0] gcnt;
  logic full, push, pop, rej_n, jam_n;
  assign raw = {coin10_raw, coin5_raw};
  // bit 0 is the 5-unit line, bit 1 the 10-unit line throughout
  // two-flop synchroniser, debounce counters and registered rising-edge events
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0 <= '0;
      s1 <= '0;
      lvl <= '0;
      lvl_q <= '0;
      ev <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s0 <= raw;
      s1 <= s0;
      lvl_q <= lvl;
      ev <= lvl & ~lvl_q;
      for (int i = 0; i < 2; i++) begin
        if (s1[i] == lvl[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt[i] <= '0;
          lvl[i] <= ~lvl[i];
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  // event arbitration, FIFO handshake and output sequencing decisions
  always_comb begin
    full = fifo_level == LW'(FIFO_DEPTH);
    pop = state == IDLE && fifo_level != '0;
    push = |ev && !jam && !(&ev) && enable && !full;
    rej_n = |ev && !jam && (&ev || !enable || full);
    jam_n = jam ? |lvl : &ev;
    state_n = state == IDLE ? (pop ? EMIT : IDLE) :
              state == EMIT ? GAP :
              (gcnt == GW'(GAP_CYCLES - 1) ? IDLE : GAP);
  end
  // coin storage; contents need no reset since the pointers gate every read
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= ev[1] ? 2'd2 : 2'd1;
  end
  // FIFO pointers, status flags, FSM state and paced outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      fifo_level <= '0;
      reject <= 1'b0;
      jam <= 1'b0;
      state <= IDLE;
      gcnt <= '0;
      coin_code <= 2'd0;
      accepted_count <= 8'd0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      reject <= rej_n;
      jam <= jam_n;
      state <= state_n;
      gcnt <= state == GAP ? gcnt + 1'b1 : '0;
      coin_code <= pop ? mem[rp] : 2'd0;
      if (state == EMIT && accepted_count != 8'hff) accepted_count <= accepted_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: randomized directed sequence checked against a timestamp/queue reference model
module tb_coin_acceptor;
  localparam int DEB = 4;
  localparam int DEPTH = 4;
  localparam int GAP = 12;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic coin5_raw = 1'b0;
  logic coin10_raw = 1'b0;
  logic enable = 1'b1;
  logic [1:0] coin_code;
  logic reject, jam;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [7:0] accepted_count;
  int ntest = 0;
  int nfail = 0;
  int t, next_pop, last_pop, macc;
  bit q5[$], q10[$], h5[$], h10[$];
  bit la5, lb5, la10, lb10, e5, e10, mjam, mrej;
  bit [1:0] mcode;
  bit [1:0] mq[$];

  coin_acceptor #(.DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .coin5_raw(coin5_raw), .coin10_raw(coin10_raw), .enable(enable),
    .coin_code(coin_code), .reject(reject), .jam(jam), .fifo_level(fifo_level),
    .accepted_count(accepted_count)
  );

  // free-running clock, period 10
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // a debounced level flips once the last DEB samples all disagree with it
  function automatic bit flips(input bit h[$], input bit l);
    if (h.size() < DEB) return 1'b0;
    for (int i = h.size() - DEB; i < h.size(); i++) if (h[i] == l) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset;
    t = 0;
    next_pop = 0;
    last_pop = -10;
    macc = 0;
    q5.delete(); q10.delete(); h5.delete(); h10.delete(); mq.delete();
    repeat (2) begin q5.push_back(1'b0); q10.push_back(1'b0); end
    {la5, lb5, la10, lb10, e5, e10, mjam, mrej} = '0;
    mcode = 2'd0;
  endtask

  task automatic model_edge(input bit r5, input bit r10, input bit en);
    int sz;
    bit d5, d10, jn;
    sz = mq.size();
    if (last_pop == t - 1 && macc < 255) macc++;
    mcode = 2'd0;
    if (t >= next_pop && sz > 0) begin
      mcode = mq.pop_front();
      last_pop = t;
      next_pop = t + GAP + 2;
    end
    mrej = 1'b0;
    jn = mjam && (la5 || la10);
    if (!mjam && (e5 || e10)) begin
      if (e5 && e10) begin jn = 1'b1; mrej = 1'b1; end
      else if (!en || sz == DEPTH) mrej = 1'b1;
      else mq.push_back(e10 ? 2'd2 : 2'd1);
    end
    mjam = jn;
    d5 = q5.pop_front(); q5.push_back(r5);
    d10 = q10.pop_front(); q10.push_back(r10);
    h5.push_back(d5); if (h5.size() > DEB) void'(h5.pop_front());
    h10.push_back(d10); if (h10.size() > DEB) void'(h10.pop_front());
    e5 = la5 && !lb5; lb5 = la5; if (flips(h5, la5)) la5 = !la5;
    e10 = la10 && !lb10; lb10 = la10; if (flips(h10, la10)) la10 = !la10;
    t++;
  endtask

  task automatic step(input bit a, input bit b);
    coin5_raw = a;
    coin10_raw = b;
    model_edge(a, b, enable);
    @(negedge clk);
    chk("coin_code", coin_code, mcode);
    chk("reject", reject, mrej);
    chk("jam", jam, mjam);
    chk("fifo_level", fifo_level, mq.size());
    chk("accepted_count", accepted_count, macc);
  endtask

  task automatic hold(input bit a, input bit b, input int n);
    repeat (n) step(a, b);
  endtask

  initial begin
    int first_hit;
    int ln, hi, lo;
    #1;
    chk("rst_coin_code", coin_code, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_accepted", accepted_count, 0);
    chk("rst_jam", jam, 0);
    chk("rst_reject", reject, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    first_hit = -1;
    for (int i = 0; i < 20; i++) begin
      step(i < 10, 1'b0);
      if (coin_code != 2'd0 && first_hit < 0) first_hit = i;
    end
    chk("latency", first_hit, DEB + 4);
    hold(0, 0, 10);
    repeat (6) begin
      ln = $urandom_range(0, 1);
      repeat ($urandom_range(1, 4)) begin
        hold(ln == 0, ln == 1, $urandom_range(1, 3));
        hold(0, 0, $urandom_range(1, 3));
      end
      hold(ln == 0, ln == 1, 10);
      hold(0, 0, 12);
    end
    hold(1, 1, 10);
    hold(0, 0, 10);
    hold(0, 1, 10);
    hold(0, 0, 30);
    enable = 1'b0;
    hold(1, 0, 10);
    hold(0, 0, 10);
    enable = 1'b1;
    repeat (10) begin
      hold(1, 0, 4);
      hold(0, 0, 4);
    end
    repeat (60) begin
      ln = $urandom_range(0, 4);
      hi = $urandom_range(4, 8);
      lo = $urandom_range(4, 8);
      enable = $urandom_range(0, 5) != 0;
      hold(ln < 2 || ln == 4, ln == 2 || ln == 3 || ln == 4, hi);
      hold(0, 0, lo);
    end
    enable = 1'b1;
    hold(0, 0, 120);
    repeat (4) begin
      hold(1, 0, 4);
      hold(0, 0, 4);
    end
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_coin_code", coin_code, 0);
    chk("mid_rst_fifo_level", fifo_level, 0);
    chk("mid_rst_accepted", accepted_count, 0);
    chk("mid_rst_jam", jam, 0);
    chk("mid_rst_reject", reject, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    hold(0, 0, 40);
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
